vend_credit_fsm: RTL and testbench
==================================

// Module: vend_credit_fsm
// PURPOSE
//  Registered vending controller: successor to the fixed 4-coin, 3-bit-state next-state logic.
//  Accepts NUM_COINS one-hot coin pulses, accumulates credit against a parametrised PRICE,
//  dispenses with a ready/ack handshake, then optionally pays change in CHANGE_UNIT pulses.
//  Sits between the coin-sensor debouncers and the dispense/change actuator drivers.
// PARAMETERS
//  NUM_COINS   4    coin channels; channel i worth vend_pkg::COIN_VAL[i]
//  CREDIT_W    8    credit register width (unsigned)
//  PRICE       75   item price in cents; 0 < PRICE <= MAX_CREDIT
//  MAX_CREDIT  200  credit ceiling; < 2**CREDIT_W
// PORTS
//  clk           in   1          single clock, all state on rising edge
//  rst_n         in   1          asynchronous, active-low reset
//  coin          in   NUM_COINS  one-cycle coin pulses, at most one bit set
//  coin_accept   out  1          pulse: coin added to credit
//  coin_reject   out  1          pulse: coin refused (multi-hot, overflow, busy)
//  credit        out  CREDIT_W   current credit, registered
//  dispense      out  1          level: item available, held until vend_ack
//  vend_ack      in   1          actuator done; sampled only in VEND
//  change_pulse  out  1          one pulse = CHANGE_UNIT cents returned (VEND_CHANGE_EN only)
//  busy          out  1          high in VEND or CHANGE
// BEHAVIOUR
//  Reset: state IDLE; credit=0; all outputs 0. Async assert, sync release.
//  States: IDLE (credit=0), ACCUM (0<credit<PRICE), VEND, CHANGE.
//  Coin cycle N (IDLE/ACCUM): coin_enc flags valid/multi; if single-hot and
//   credit+COIN_VAL<=MAX_CREDIT -> coin_accept@N+1, credit updated @N+1; else coin_reject@N+1,
//   credit unchanged. Zero-hot: no action. Multi-hot: reject, never partially credited.
//  Sum computed in CREDIT_W+1 bits; overflow check on the wide sum.
//  credit>=PRICE after update -> VEND next cycle; dispense=1 from VEND entry.
//  Coins in VEND/CHANGE: coin_reject pulse, credit unchanged.
//  VEND & vend_ack: credit<=credit-PRICE; dispense falls next cycle;
//   remainder>0 -> CHANGE (macro on) else IDLE. vend_ack outside VEND ignored.
//  CHANGE: change_pulse every cycle, credit-=CHANGE_UNIT; credit hits 0 -> IDLE same edge.
//  Simultaneous coin and vend_ack in VEND: ack processed, coin rejected.
//  Reset mid-VEND/CHANGE: credit lost, dispense/change_pulse drop immediately (async).
// CONFIGURATION
//  VEND_CHANGE_EN defined: CHANGE state and change_pulse active as above.
//  Undefined: no CHANGE state; after ack remainder discarded, credit<=0, IDLE;
//   change_pulse tied 0. Exact overpayment still dispenses.
// STRUCTURE
//  vend_pkg: state_e enum {IDLE,ACCUM,VEND,CHANGE}; COIN_VAL[] = {5,10,25,100};
//   CHANGE_UNIT=5; all COIN_VAL and PRICE multiples of CHANGE_UNIT (static assertion).
//  Sub-module coin_enc #(NUM_COINS): one-hot -> index, valid, multi flags; combinational,
//   generalised N:log2(N) encoder. Top holds state, credit and output registers.
// TESTING
//  1 reset mid-ACCUM with credit=50 -> credit=0, outputs 0, IDLE on release.
//  2 coins 25,25,25 -> accept x3, credit 25/50/75, dispense@cycle after 3rd accept;
//    ack -> credit 0, IDLE, no change_pulse.
//  3 macro on: 100 -> VEND; ack -> credit 25, 5 change_pulses, IDLE.
//  4 macro off: same -> dispense, ack, credit 0, change_pulse never high.
//  5 coin=4'b0011 -> coin_reject, credit unchanged; credit 180 + 100 -> reject (>200).
//  6 coin 10 in VEND same cycle as ack -> reject, ack honoured; ack in IDLE ignored.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, coin table and parameter checks for the vending controller
// Contents: state_e, COIN_VAL[], CHANGE_UNIT, cfg_ok() legality check for a parameter set.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_e;

    localparam int COIN_CHANNELS   = 4;
    localparam int COIN_VAL [COIN_CHANNELS] = '{5, 10, 25, 100};
    localparam int CHANGE_UNIT     = 5;

    // Change can only be paid out exactly if every coin and the price are whole units.
    function automatic bit cfg_ok(input int price, input int max_credit,
                                  input int credit_w, input int num_coins);
        bit ok;
        ok = (price > 0) && (price <= max_credit) && (max_credit < (1 << credit_w)) &&
             (num_coins >= 1) && (num_coins <= COIN_CHANNELS) && ((price % CHANGE_UNIT) == 0);
        for (int i = 0; i < COIN_CHANNELS; i++) begin
            if ((COIN_VAL[i] % CHANGE_UNIT) != 0) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/vend_credit_fsm_if.sv
// rtl/vend_credit_fsm_if.sv - coin/dispense/change signal bundle for the vending controller
// master: coin-sensor / actuator side, drives coin and vend_ack.
// slave : vend_credit_fsm, drives coin_accept, coin_reject, credit, dispense, change_pulse, busy.
interface vend_credit_fsm_if #(
    parameter int NUM_COINS = 4,
    parameter int CREDIT_W  = 8
);
    logic [NUM_COINS-1:0] coin;
    logic                 coin_accept;
    logic                 coin_reject;
    logic [CREDIT_W-1:0]  credit;
    logic                 dispense;
    logic                 vend_ack;
    logic                 change_pulse;
    logic                 busy;

    modport master (
        output coin, vend_ack,
        input  coin_accept, coin_reject, credit, dispense, change_pulse, busy
    );

    modport slave (
        input  coin, vend_ack,
        output coin_accept, coin_reject, credit, dispense, change_pulse, busy
    );
endinterface

// File: rtl/coin_enc.sv
// rtl/coin_enc.sv - combinational N:log2(N) one-hot coin encoder with valid/multi flags
// Ports: onehot_i (coin pulses) -> idx_o (highest set channel), valid_o (any set), multi_o (>1 set).
module coin_enc #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  onehot_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o,
    output logic          multi_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        multi_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                if (valid_o) multi_o = 1'b1;
                valid_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/vend_credit_fsm.sv
// rtl/vend_credit_fsm.sv - registered coin-credit vending controller with dispense handshake
// Ports: clk, rst_n (async active-low); bus (vend_credit_fsm_if.slave): coin, vend_ack in;
//        coin_accept, coin_reject, credit, dispense, change_pulse, busy out (all registered).
// Build option: VEND_CHANGE_EN enables the CHANGE state and change_pulse payout.
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int NUM_COINS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int PRICE      = 75,
    parameter int MAX_CREDIT = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    vend_credit_fsm_if.slave bus
);

    localparam int IW  = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
    localparam int CW1 = CREDIT_W + 1;

    if (!cfg_ok(PRICE, MAX_CREDIT, CREDIT_W, NUM_COINS)) begin : g_bad_cfg
        $error("vend_credit_fsm: illegal parameter set");
    end

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                coin_accept_q;
    logic                coin_reject_q;
    logic                dispense_q;
    logic                busy_q;

    logic [IW-1:0]       enc_idx;
    logic                enc_valid;
    logic                enc_multi;
    logic [CW1-1:0]      coin_val;
    logic [CW1-1:0]      credit_sum_d;

    coin_enc #(.N(NUM_COINS)) u_coin_enc (
        .onehot_i (bus.coin),
        .idx_o    (enc_idx),
        .valid_o  (enc_valid),
        .multi_o  (enc_multi)
    );

    // One extra bit so the ceiling check sees the true sum rather than a wrapped one.
    assign coin_val     = CW1'(COIN_VAL[enc_idx]);
    assign credit_sum_d = {1'b0, credit_q} + coin_val;

`ifdef VEND_CHANGE_EN
    logic                change_pulse_q;
    logic [CREDIT_W-1:0] credit_rem_d;
    logic [CREDIT_W-1:0] credit_step_d;
    assign credit_rem_d     = credit_q - CREDIT_W'(PRICE);
    assign credit_step_d    = credit_q - CREDIT_W'(CHANGE_UNIT);
    assign bus.change_pulse = change_pulse_q;
`else
    assign bus.change_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            coin_accept_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            dispense_q     <= 1'b0;
            busy_q         <= 1'b0;
`ifdef VEND_CHANGE_EN
            change_pulse_q <= 1'b0;
`endif
        end else begin
            coin_accept_q <= 1'b0;
            coin_reject_q <= 1'b0;
            case (state_q)
                IDLE, ACCUM: begin
                    // Price reached on the previous accept: move to VEND this edge and
                    // refuse any coin that arrives in this hand-over cycle.
                    if (credit_q >= CREDIT_W'(PRICE)) begin
                        state_q    <= VEND;
                        dispense_q <= 1'b1;
                        busy_q     <= 1'b1;
                        if (enc_valid) coin_reject_q <= 1'b1;
                    end else if (enc_valid) begin
                        if (!enc_multi && (credit_sum_d <= CW1'(MAX_CREDIT))) begin
                            coin_accept_q <= 1'b1;
                            credit_q      <= credit_sum_d[CREDIT_W-1:0];
                            state_q       <= ACCUM;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    if (enc_valid) coin_reject_q <= 1'b1;
                    if (bus.vend_ack) begin
                        dispense_q <= 1'b0;
`ifdef VEND_CHANGE_EN
                        if (credit_rem_d != '0) begin
                            state_q        <= CHANGE;
                            credit_q       <= credit_rem_d;
                            change_pulse_q <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            credit_q <= '0;
                            busy_q   <= 1'b0;
                        end
`else
                        state_q  <= IDLE;
                        credit_q <= '0;
                        busy_q   <= 1'b0;
`endif
                    end
                end
                CHANGE: begin
                    if (enc_valid) coin_reject_q <= 1'b1;
`ifdef VEND_CHANGE_EN
                    // change_pulse is high for each cycle whose CHANGE_UNIT is removed at its end.
                    credit_q <= credit_step_d;
                    if (credit_step_d == '0) begin
                        state_q        <= IDLE;
                        change_pulse_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end
`else
                    state_q  <= IDLE;
                    credit_q <= '0;
                    busy_q   <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.coin_accept = coin_accept_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.credit      = credit_q;
    assign bus.dispense    = dispense_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// tb/tb_vend_credit_fsm.sv - directed-vector bench for vend_credit_fsm (default and PRICE=200 instances)
module tb_vend_credit_fsm;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    vend_credit_fsm_if #(.NUM_COINS(4), .CREDIT_W(8)) bm ();
    vend_credit_fsm_if #(.NUM_COINS(4), .CREDIT_W(8)) bh ();

    vend_credit_fsm #(.NUM_COINS(4), .CREDIT_W(8), .PRICE(75), .MAX_CREDIT(200)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bm)
    );

    vend_credit_fsm #(.NUM_COINS(4), .CREDIT_W(8), .PRICE(200), .MAX_CREDIT(200)) u_dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one coin for one cycle from a falling edge, then check the registered response.
    task automatic put_coin(input bit hi, input logic [3:0] c, input bit exp_acc,
                            input bit exp_rej, input int exp_cr, input string tag);
        if (hi) bh.coin = c; else bm.coin = c;
        @(negedge clk);
        bh.coin = '0;
        bm.coin = '0;
        chk({tag, ".acc"}, hi ? bh.coin_accept : bm.coin_accept, 32'(exp_acc));
        chk({tag, ".rej"}, hi ? bh.coin_reject : bm.coin_reject, 32'(exp_rej));
        chk({tag, ".credit"}, hi ? bh.credit : bm.credit, 32'(exp_cr));
    endtask

    task automatic pulse_ack();
        bm.vend_ack = 1'b1;
        @(negedge clk);
        bm.vend_ack = 1'b0;
    endtask

    initial begin
        int cnt;
        int exp_rem;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bm.coin = '0; bm.vend_ack = 1'b0;
        bh.coin = '0; bh.vend_ack = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst.credit",   bm.credit, 0);
        chk("rst.dispense", bm.dispense, 0);
        chk("rst.busy",     bm.busy, 0);
        chk("rst.acc",      bm.coin_accept, 0);
        chk("rst.change",   bm.change_pulse, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // three quarters, exact price
        put_coin(0, 4'b0100, 1, 0, 25, "t2.c1");
        put_coin(0, 4'b0100, 1, 0, 50, "t2.c2");
        put_coin(0, 4'b0100, 1, 0, 75, "t2.c3");
        chk("t2.disp_early", bm.dispense, 0);
        @(negedge clk);
        chk("t2.dispense", bm.dispense, 1);
        chk("t2.busy",     bm.busy, 1);
        pulse_ack();
        chk("t2.ack.credit", bm.credit, 0);
        chk("t2.ack.disp",   bm.dispense, 0);
        chk("t2.ack.busy",   bm.busy, 0);
        chk("t2.ack.change", bm.change_pulse, 0);

        // dollar coin, overpayment of 25
        put_coin(0, 4'b1000, 1, 0, 100, "t3.c100");
        @(negedge clk);
        chk("t3.dispense", bm.dispense, 1);
        put_coin(0, 4'b0001, 0, 1, 100, "t6.coin_in_vend");
        chk("t6.disp_held", bm.dispense, 1);
        pulse_ack();
`ifdef VEND_CHANGE_EN
        exp_rem = 25;
`else
        exp_rem = 0;
`endif
        chk("t3.ack.credit", bm.credit, 32'(exp_rem));
        chk("t3.ack.disp",   bm.dispense, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bm.change_pulse) cnt++;
            @(negedge clk);
        end
        chk("t3.pulses", 32'(cnt), 32'(exp_rem / 5));
        chk("t3.end.credit", bm.credit, 0);
        chk("t3.end.busy",   bm.busy, 0);

        // reset mid-ACCUM with credit 50
        put_coin(0, 4'b0100, 1, 0, 25, "t1.c1");
        put_coin(0, 4'b0100, 1, 0, 50, "t1.c2");
        rst_n = 1'b0;
        #1;
        chk("t1.async.credit", bm.credit, 0);
        chk("t1.async.busy",   bm.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1.rel.credit", bm.credit, 0);
        put_coin(0, 4'b0100, 1, 0, 25, "t1.after");
        put_coin(0, 4'b0100, 1, 0, 50, "t1.c3");
        put_coin(0, 4'b0100, 1, 0, 75, "t1.c4");
        @(negedge clk);
        chk("t1.vend.disp", bm.dispense, 1);
        rst_n = 1'b0;
        #1;
        chk("t1.vend.rst.disp",   bm.dispense, 0);
        chk("t1.vend.rst.credit", bm.credit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // coin together with ack in VEND; ack outside VEND
        put_coin(0, 4'b0100, 1, 0, 25, "t6.c1");
        put_coin(0, 4'b0100, 1, 0, 50, "t6.c2");
        put_coin(0, 4'b0100, 1, 0, 75, "t6.c3");
        @(negedge clk);
        chk("t6.dispense", bm.dispense, 1);
        bm.coin = 4'b0010;
        bm.vend_ack = 1'b1;
        @(negedge clk);
        bm.coin = '0;
        bm.vend_ack = 1'b0;
        chk("t6.both.rej",    bm.coin_reject, 1);
        chk("t6.both.acc",    bm.coin_accept, 0);
        chk("t6.both.credit", bm.credit, 0);
        chk("t6.both.disp",   bm.dispense, 0);
        pulse_ack();
        chk("t6.idle_ack.credit", bm.credit, 0);
        chk("t6.idle_ack.busy",   bm.busy, 0);
        put_coin(0, 4'b0010, 1, 0, 10, "t6.c10");
        pulse_ack();
        chk("t6.accum_ack.credit", bm.credit, 10);
        chk("t6.accum_ack.disp",   bm.dispense, 0);

        // multi-hot and zero-hot
        put_coin(0, 4'b0011, 0, 1, 10, "t5.multi");
        put_coin(0, 4'b0000, 0, 0, 10, "t5.none");

        // ceiling on the PRICE=200 instance
        put_coin(1, 4'b1000, 1, 0, 100, "t5.h1");
        put_coin(1, 4'b0100, 1, 0, 125, "t5.h2");
        put_coin(1, 4'b0100, 1, 0, 150, "t5.h3");
        put_coin(1, 4'b0100, 1, 0, 175, "t5.h4");
        put_coin(1, 4'b0001, 1, 0, 180, "t5.h5");
        put_coin(1, 4'b1000, 0, 1, 180, "t5.over");
        put_coin(1, 4'b1100, 0, 1, 180, "t5.hmulti");
        put_coin(1, 4'b0010, 1, 0, 190, "t5.h6");
        put_coin(1, 4'b0010, 1, 0, 200, "t5.atmax");
        @(negedge clk);
        chk("t5.hi.dispense", bh.dispense, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
